// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and helpers for the multi-chain scan wrapper
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPT,
    ST_UNLD,
    ST_DONE
  } seq_state_e;

  // Widest signature the compactor helper handles; SIG_W must not exceed this.
  localparam int SIG_MAX = 64;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  // One compactor step on the low `width` bits: rotate left by one, then XOR in din.
  function automatic logic [SIG_MAX-1:0] sig_step(input logic [SIG_MAX-1:0] sig,
                                                  input logic [SIG_MAX-1:0] din,
                                                  input int width);
    logic [SIG_MAX-1:0] rot;
    rot = '0;
    for (int i = 0; i < SIG_MAX; i++) begin
      if (i == 0) begin
        rot[i] = sig[width-1];
      end else if (i < width) begin
        rot[i] = sig[i-1];
      end
    end
    return rot ^ din;
  endfunction

endpackage

// File: rtl/scan_seq_fsm.sv
// rtl/scan_seq_fsm.sv - load/capture/unload sequencer with shift counter
module scan_seq_fsm
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic test_mode_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic shift_en_o,
  output logic capt_en_o,
  output logic sig_clr_o,
  output logic sig_upd_o
);

  localparam int CNT_W = clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and shift counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and per-cycle controls; dropping test_mode aborts any busy state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_en_o = 1'b0;
    capt_en_o  = 1'b0;
    sig_clr_o  = 1'b0;
    sig_upd_o  = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_i && test_mode_i) begin
          state_d   = ST_LOAD;
          sig_clr_o = 1'b1;
        end
      end
      ST_LOAD: begin
        shift_en_o = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPT: begin
        capt_en_o = 1'b1;
        state_d   = ST_UNLD;
        cnt_d     = '0;
      end
      ST_UNLD: begin
        shift_en_o = 1'b1;
        sig_upd_o  = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (state_q != ST_IDLE && !test_mode_i) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      shift_en_o = 1'b0;
      capt_en_o  = 1'b0;
      sig_upd_o  = 1'b0;
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/scan_wrapper_mc.sv
// rtl/scan_wrapper_mc.sv - multi-chain scan wrapper around a registered accumulator
module scan_wrapper_mc
  import scan_pkg::*;
#(
  parameter int N_CHAINS  = 2,
  parameter int CHAIN_LEN = 8,
  parameter int DATA_W    = N_CHAINS * CHAIN_LEN,
  parameter int SIG_W     = 16
) (
  input  logic                refclk,
  input  logic                reset,
  input  logic                test_mode,
  input  logic                se,
  input  logic [N_CHAINS-1:0] si,
  output logic [N_CHAINS-1:0] so,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [SIG_W-1:0]    signature
);

  logic [DATA_W-1:0]  q_q, q_d, q_shift;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [SIG_MAX-1:0] sig_next;
  logic               seq_shift, seq_capt, sig_clr, sig_upd;
  logic               do_shift, do_capt;

  scan_seq_fsm #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_seq (
    .clk_i       (refclk),
    .reset_i     (reset),
    .test_mode_i (test_mode),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .shift_en_o  (seq_shift),
    .capt_en_o   (seq_capt),
    .sig_clr_o   (sig_clr),
    .sig_upd_o   (sig_upd)
  );

  // Per-chain shift toward bit 0; so taps the LSB flop of each chain.
  always_comb begin
    q_shift = '0;
    so      = '0;
    for (int c = 0; c < N_CHAINS; c++) begin
      q_shift[c*CHAIN_LEN +: CHAIN_LEN] = {si[c], q_q[c*CHAIN_LEN+1 +: CHAIN_LEN-1]};
      so[c] = q_q[c*CHAIN_LEN];
    end
  end

  // Mode select: a busy sequencer owns shift/capture; otherwise test_mode/se decide.
  always_comb begin
    do_shift = busy ? seq_shift : (test_mode && se);
    do_capt  = busy ? seq_capt  : (!test_mode || !se);
    q_d      = q_q;
    if (do_shift) begin
      q_d = q_shift;
    end else if (do_capt) begin
      q_d = q_q + data_in;
    end
  end

  // Signature compacts the pre-shift scan-out during unload only.
  always_comb begin
    sig_next = sig_step(SIG_MAX'(sig_q), SIG_MAX'(so), SIG_W);
    sig_d    = sig_q;
    if (sig_clr) begin
      sig_d = '0;
    end else if (sig_upd) begin
      sig_d = sig_next[SIG_W-1:0];
    end
  end

  // Core register and signature register.
  always_ff @(posedge refclk) begin
    if (reset) begin
      q_q   <= '0;
      sig_q <= '0;
    end else begin
      q_q   <= q_d;
      sig_q <= sig_d;
    end
  end

  assign data_out  = q_q;
  assign signature = sig_q;

endmodule
